// File: rtl/game_ring.sv
// Turn-taking ring game: players press buttons in turn, and move codes advance the turn.
// Out-of-turn presses, bad codes and turn timeouts end the round with a recorded loser.
module game_ring #(
    parameter int unsigned N_PLAYERS = 6,
    parameter int unsigned TIMEOUT   = 1000,
    parameter int unsigned DIR_LEFT  = 1,
    localparam int unsigned PW       = $clog2(N_PLAYERS + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3*N_PLAYERS-1:0]   move,
    input  logic [N_PLAYERS-1:0]     press,
    input  logic                     start,
    output logic [PW-1:0]            turn,
    output logic [PW-1:0]            loser,
    output logic                     lost,
    output logic [7:0]               move_cnt
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StPlay = 2'd1;
    localparam logic [1:0] StLost = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        turn_q, turn_d;
    logic [PW-1:0]        loser_q, loser_d;
    logic [7:0]           cnt_q, cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [N_PLAYERS-1:0] press_q;
    logic [N_PLAYERS-1:0] rise, cur_mask, others;
    logic [2:0]           cur_code;
    logic [PW-1:0]        first_other;

    // Player numbers are 1-based; step around the ring in the configured direction.
    function automatic logic [PW-1:0] advance(input logic [PW-1:0] t, input int unsigned step);
        int unsigned idx;
        if (DIR_LEFT != 0) begin
            idx = (32'(t) - 1 + step) % N_PLAYERS;
        end else begin
            idx = (32'(t) - 1 + N_PLAYERS - step) % N_PLAYERS;
        end
        return PW'(idx + 1);
    endfunction

    always_comb begin
        rise     = press & ~press_q;
        cur_mask = '0;
        cur_code = '0;
        for (int unsigned k = 0; k < N_PLAYERS; k++) begin
            if (32'(turn_q) == k + 1) begin
                cur_mask[k] = 1'b1;
                cur_code    = move[3*k +: 3];
            end
        end
        others      = rise & ~cur_mask;
        // Scan downwards so the lowest-numbered offender wins.
        first_other = '0;
        for (int unsigned k = N_PLAYERS; k > 0; k--) begin
            if (others[k-1]) begin
                first_other = PW'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        turn_d  = turn_q;
        loser_d = loser_q;
        cnt_d   = cnt_q;
        timer_d = timer_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPlay;
                    turn_d  = PW'(1);
                    loser_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            end
            StPlay: begin
                if (|others) begin
                    state_d = StLost;
                    loser_d = first_other;
                    turn_d  = '0;
                end else if (|(rise & cur_mask)) begin
                    if (cur_code == 3'd2 || cur_code == 3'd1) begin
                        turn_d  = advance(turn_q, (cur_code == 3'd2) ? 1 : 2);
                        cnt_d   = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
                        timer_d = '0;
                    end else begin
                        state_d = StLost;
                        loser_d = turn_q;
                        turn_d  = '0;
                    end
                end else if (TIMEOUT != 0) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = StLost;
                        loser_d = turn_q;
                        turn_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            StLost: begin
                if (start) begin
                    state_d = StPlay;
                    turn_d  = loser_q;
                    loser_d = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                turn_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            turn_q  <= '0;
            loser_q <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            press_q <= '0;
        end else begin
            state_q <= state_d;
            turn_q  <= turn_d;
            loser_q <= loser_d;
            cnt_q   <= cnt_d;
            timer_q <= timer_d;
            press_q <= press;
        end
    end

    assign turn     = turn_q;
    assign loser    = loser_q;
    assign lost     = (state_q == StLost);
    assign move_cnt = cnt_q;

endmodule

// File: tb/tb_game_ring.sv
// Bench for game_ring: two instances (clockwise with timeout 8, counter-clockwise without
// timeout) share stimulus; a rule-level model is compared every cycle plus directed literals.
module tb_game_ring;

    localparam int MIdle = 0;
    localparam int MPlay = 1;
    localparam int MLost = 2;

    logic        clk;
    logic        reset;
    logic [17:0] move;
    logic [5:0]  press;
    logic        start;
    logic [2:0]  a_turn, a_loser, b_turn, b_loser;
    logic        a_lost, b_lost;
    logic [7:0]  a_cnt, b_cnt;

    int checks = 0;
    int errors = 0;

    game_ring #(.N_PLAYERS(6), .TIMEOUT(8), .DIR_LEFT(1)) dut_a (
        .clk(clk), .reset(reset), .move(move), .press(press), .start(start),
        .turn(a_turn), .loser(a_loser), .lost(a_lost), .move_cnt(a_cnt)
    );

    game_ring #(.N_PLAYERS(6), .TIMEOUT(0), .DIR_LEFT(0)) dut_b (
        .clk(clk), .reset(reset), .move(move), .press(press), .start(start),
        .turn(b_turn), .loser(b_loser), .lost(b_lost), .move_cnt(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_mode [2];
    int         m_turn [2];
    int         m_loser[2];
    int         m_cnt  [2];
    int         m_timer[2];
    logic [5:0] m_prev [2];

    task automatic model_lose(input int i, input int who);
        m_mode[i]  = MLost;
        m_loser[i] = who;
        m_turn[i]  = 0;
    endtask

    task automatic model_step(input int i, input int dirl, input int tmo);
        logic [5:0] r;
        int lowest, code, step;
        if (reset) begin
            m_mode[i] = MIdle; m_turn[i] = 0; m_loser[i] = 0;
            m_cnt[i] = 0; m_timer[i] = 0; m_prev[i] = '0;
            return;
        end
        r = press & ~m_prev[i];
        m_prev[i] = press;
        if (m_mode[i] == MIdle || m_mode[i] == MLost) begin
            if (start) begin
                m_turn[i]  = (m_mode[i] == MIdle) ? 1 : m_loser[i];
                m_mode[i]  = MPlay;
                m_loser[i] = 0;
                m_cnt[i]   = 0;
                m_timer[i] = 0;
            end
            return;
        end
        lowest = 0;
        for (int p = 6; p >= 1; p--) begin
            if (r[p-1] && p != m_turn[i]) lowest = p;
        end
        if (lowest != 0) begin
            model_lose(i, lowest);
        end else if (r[m_turn[i]-1]) begin
            code = int'(move[3*(m_turn[i]-1) +: 3]);
            if (code == 1 || code == 2) begin
                step = (code == 2) ? 1 : 2;
                if (dirl != 0) m_turn[i] = ((m_turn[i] - 1 + step) % 6) + 1;
                else           m_turn[i] = ((m_turn[i] - 1 - step + 6) % 6) + 1;
                if (m_cnt[i] < 255) m_cnt[i]++;
                m_timer[i] = 0;
            end else begin
                model_lose(i, m_turn[i]);
            end
        end else if (tmo > 0) begin
            if (m_timer[i] == tmo - 1) model_lose(i, m_turn[i]);
            else m_timer[i]++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step(0, 1, 8);
            model_step(1, 0, 0);
            #1;
            chk("model_a_turn",  32'(a_turn),  32'(m_turn[0]));
            chk("model_a_loser", 32'(a_loser), 32'(m_loser[0]));
            chk("model_a_lost",  32'(a_lost),  32'(m_mode[0] == MLost));
            chk("model_a_cnt",   32'(a_cnt),   32'(m_cnt[0]));
            chk("model_b_turn",  32'(b_turn),  32'(m_turn[1]));
            chk("model_b_loser", 32'(b_loser), 32'(m_loser[1]));
            chk("model_b_lost",  32'(b_lost),  32'(m_mode[1] == MLost));
            chk("model_b_cnt",   32'(b_cnt),   32'(m_cnt[1]));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_move(input int p, input logic [2:0] code);
        move[3*(p-1) +: 3] = code;
    endtask

    task automatic tap(input logic [5:0] mask);
        press = mask;
        cyc(1);
        press = '0;
        cyc(1);
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        press = '0;
        move  = '0;
        cyc(2);
        chk("reset_turn",  32'(a_turn),  0);
        chk("reset_lost",  32'(a_lost),  0);
        chk("reset_cnt",   32'(a_cnt),   0);
        chk("reset_loser", 32'(a_loser), 0);
        reset = 1'b0;
        cyc(1);
        chk("idle_turn", 32'(a_turn), 0);

        // Normal play
        do_start();
        chk("start_turn", 32'(a_turn), 1);
        chk("start_cnt",  32'(a_cnt),  0);
        set_move(1, 3'd2);
        set_move(2, 3'd1);
        set_move(4, 3'd3);
        tap(6'b000001);
        chk("p1_turn", 32'(a_turn), 2);
        chk("p1_cnt",  32'(a_cnt),  1);
        chk("b_wrap_turn", 32'(b_turn), 6);
        tap(6'b000010);
        chk("p2_turn", 32'(a_turn), 4);
        chk("p2_cnt",  32'(a_cnt),  2);
        chk("b_out_of_turn_lost",  32'(b_lost),  1);
        chk("b_out_of_turn_loser", 32'(b_loser), 2);
        tap(6'b001000);
        chk("p4_lost",  32'(a_lost),  1);
        chk("p4_loser", 32'(a_loser), 4);
        chk("p4_turn",  32'(a_turn),  0);
        chk("p4_cnt_hold", 32'(a_cnt), 2);

        // Restart from LOST, then wrap 5 -> 1
        do_start();
        chk("restart_turn",  32'(a_turn),  4);
        chk("restart_loser", 32'(a_loser), 0);
        chk("restart_lost",  32'(a_lost),  0);
        chk("restart_cnt",   32'(a_cnt),   0);
        set_move(4, 3'd2);
        set_move(5, 3'd1);
        tap(6'b001000);
        chk("p4b_turn", 32'(a_turn), 5);
        tap(6'b010000);
        chk("wrap_turn", 32'(a_turn), 1);
        chk("wrap_cnt",  32'(a_cnt),  2);

        // Out-of-turn priority
        tap(6'b000001);
        chk("pre_prio_turn", 32'(a_turn), 2);
        set_move(2, 3'd2);
        tap(6'b010110);
        chk("prio_lost",  32'(a_lost),  1);
        chk("prio_loser", 32'(a_loser), 3);
        chk("prio_cnt",   32'(a_cnt),   3);

        // Invalid code, then held press across restart
        set_move(3, 3'd2);
        set_move(4, 3'd7);
        do_start();
        chk("restart3_turn", 32'(a_turn), 3);
        tap(6'b000100);
        chk("p3_turn", 32'(a_turn), 4);
        press = 6'b001000;
        cyc(1);
        chk("bad_code_lost",  32'(a_lost),  1);
        chk("bad_code_loser", 32'(a_loser), 4);
        do_start();
        cyc(2);
        chk("held_no_event_lost", 32'(a_lost), 0);
        chk("held_no_event_turn", 32'(a_turn), 4);
        press = '0;
        cyc(1);

        // Timeout
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        do_start();
        cyc(7);
        chk("timeout_early_lost", 32'(a_lost), 0);
        cyc(1);
        chk("timeout_lost",  32'(a_lost),  1);
        chk("timeout_loser", 32'(a_loser), 1);
        chk("b_no_timeout",  32'(b_lost),  0);
        tap(6'b000010);
        chk("lost_ignores_press", 32'(a_loser), 1);

        // Reset mid-PLAY
        do_start();
        tap(6'b000001);
        chk("pre_reset_turn", 32'(a_turn), 2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("midreset_turn", 32'(a_turn), 0);
        chk("midreset_cnt",  32'(a_cnt),  0);
        chk("midreset_lost", 32'(a_lost), 0);
        cyc(3);
        chk("stay_idle_turn", 32'(a_turn), 0);
        chk("stay_idle_b",    32'(b_turn), 0);

        cyc(1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
